fft8_out_serializer: RTL

Output-side reader for the 8-point FFT pipeline. Captures one complete parallel frame of eight complex bins from the final FFT stage, which delivers them in bit-reversed lane order. Streams the bins out one per cycle in natural order (bin 0..7) over a valid/ready interface. A two-bank ping-pong buffer lets the FFT deliver a new frame every 8 cycles without stalling while the consumer keeps `out_ready` high.

---
 rtl/fft8_out_serializer.sv | 97 +++++++++
 1 files changed

// File: rtl/fft8_out_serializer.sv
// Bit-reversed 8-bin FFT frame capture with ping-pong banks and natural-order
// streaming. Define FFT_OUT_SCALE_EN to arithmetic-shift outputs right by 3.
module fft8_out_serializer #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [8*DW-1:0] in_re,
  input  logic [8*DW-1:0] in_im,
  output logic            in_ready,
  output logic            frame_drop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [2:0]      out_idx,
  output logic            out_last
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_st_t;

  bank_st_t st [2];
  logic     wr_bank;
  logic     rd_bank;
  logic [2:0] rd_idx;

  logic signed [DW-1:0] mem_re [2][8];
  logic signed [DW-1:0] mem_im [2][8];
  logic signed [DW-1:0] cur_re;
  logic signed [DW-1:0] cur_im;

  logic accept;
  logic pop;

  function automatic int bitrev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  assign in_ready  = (st[wr_bank] == EMPTY);
  assign out_valid = (st[rd_bank] == FULL);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_idx     <= 3'd0;
      frame_drop <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < 8; n++) begin
          mem_re[b][n] <= '0;
          mem_im[b][n] <= '0;
        end
      end
    end else begin
      frame_drop <= in_valid && !in_ready;
      // The write bank is EMPTY here, so it never collides with the pop bank.
      if (accept) begin
        for (int n = 0; n < 8; n++) begin
          mem_re[wr_bank][n] <= in_re[bitrev(n)*DW +: DW];
          mem_im[wr_bank][n] <= in_im[bitrev(n)*DW +: DW];
        end
        st[wr_bank] <= FULL;
        wr_bank     <= ~wr_bank;
      end
      if (pop) begin
        rd_idx <= rd_idx + 3'd1;
        if (rd_idx == 3'd7) begin
          st[rd_bank] <= EMPTY;
          rd_bank     <= ~rd_bank;
        end
      end
    end
  end

  assign cur_re = mem_re[rd_bank][rd_idx];
  assign cur_im = mem_im[rd_bank][rd_idx];

`ifdef FFT_OUT_SCALE_EN
  assign out_re = cur_re >>> 3;
  assign out_im = cur_im >>> 3;
`else
  assign out_re = cur_re;
  assign out_im = cur_im;
`endif

  assign out_idx  = rd_idx;
  assign out_last = out_valid && (rd_idx == 3'd7);

endmodule
